// File: rtl/fpu_wb_merge.sv
// rtl/fpu_wb_merge.sv - FP register-file write-back merge with div/sqrt FIFO and pending-write scoreboard
// Optional checker: define FPU_WB_ERRCHK_EN to enable the sticky err flag.
module fpu_wb_merge #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   fp_v,
  input  logic [AW-1:0]          fp_rd,
  input  logic [DW-1:0]          fp_d,
  input  logic                   ld_v,
  input  logic [AW-1:0]          ld_rd,
  input  logic [DW-1:0]          ld_d,
  input  logic                   div_v,
  input  logic [AW-1:0]          div_rd,
  input  logic [DW-1:0]          div_d,
  output logic                   div_rdy,
  input  logic                   iss_v,
  input  logic [AW-1:0]          iss_rd,
  output logic                   wex,
  output logic [AW-1:0]          wnx,
  output logic [DW-1:0]          dx,
  output logic                   wey,
  output logic [AW-1:0]          wny,
  output logic [DW-1:0]          dy,
  output logic [31:0]            pend,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_rd [DEPTH];
  logic [DW-1:0] q_d  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_d;
  logic [31:0]   pend_n;

  assign div_rdy = (fifo_cnt < CW'(DEPTH));
  assign push    = div_v & div_rdy;
  assign head_rd = q_rd[rd_ptr];
  assign head_d  = q_d[rd_ptr];
  // A same-register FP result in flight holds the head so Y priority cannot clobber the younger value.
  assign pop     = !ld_v && (fifo_cnt != '0) && !(fp_v && (fp_rd == head_rd));

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr] <= div_rd;
      q_d[wr_ptr]  <= div_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wex <= 1'b0;
      wnx <= '0;
      dx  <= '0;
    end else begin
      wex <= fp_v;
      wnx <= fp_rd;
      dx  <= fp_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wey <= 1'b0;
      wny <= '0;
      dy  <= '0;
    end else if (ld_v) begin
      wey <= 1'b1;
      wny <= ld_rd;
      dy  <= ld_d;
    end else if (pop) begin
      wey <= 1'b1;
      wny <= head_rd;
      dy  <= head_d;
    end else begin
      wey <= 1'b0;
    end
  end

  // Clears follow the registered write ports; a same-edge issue to that register wins.
  always_comb begin
    pend_n = pend;
    if (wex) pend_n[wnx] = 1'b0;
    if (wey) pend_n[wny] = 1'b0;
    if (iss_v) pend_n[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) pend <= '0;
    else       pend <= pend_n;
  end

`ifdef FPU_WB_ERRCHK_EN
  logic [6:0] stall_cnt;
  logic       stall;
  logic       same_clr;
  logic       hit;

  assign stall    = div_v & !div_rdy;
  assign same_clr = (wex && (wnx == iss_rd)) || (wey && (wny == iss_rd));
  // stall_cnt counts earlier consecutive stalled cycles, so >=64 here means the 65th.
  assign hit = (ld_v && fp_v && (ld_rd == fp_rd))
            || (iss_v && pend[iss_rd] && !same_clr)
            || (stall && (stall_cnt >= 7'd64));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (!stall)                  stall_cnt <= '0;
      else if (stall_cnt != 7'h7F) stall_cnt <= stall_cnt + 7'd1;
      err <= err | hit;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
